// File: rtl/cve2_pkg.sv
// Shared types for the multiply/divide issue path: operator encoding, issue FSM
// states, intermediate-value width and the registered request bundle.
package cve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MDI_IDLE,
    MDI_BUSY,
    MDI_RESP,
    MDI_DRAIN
  } md_issue_fsm_e;

  localparam int unsigned MD_IMD_W = 34;

  // Operands held stable toward the multdiv for the whole operation
  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } md_req_t;

endpackage

// File: rtl/cve2_multdiv_imd_regs.sv
// Write-enabled intermediate-value registers used by the iterative multdiv.
// Writes are only honoured while an operation is running or draining.
module cve2_multdiv_imd_regs
  import cve2_pkg::*;
#(
  parameter int unsigned NumImd = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [NumImd-1:0]                  we,
  input  logic [NumImd-1:0][MD_IMD_W-1:0]    d,
  output logic [NumImd-1:0][MD_IMD_W-1:0]    q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NumImd; i++) begin
        if (en && we[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/cve2_multdiv_issue.sv
// Requester-side controller for the slow multdiv: request handshake, operand
// hold, kill/flush draining and a single-entry registered response buffer.
module cve2_multdiv_issue
  import cve2_pkg::*;
#(
  parameter int unsigned TagWidth = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  md_op_e                        req_op_i,
  input  logic [1:0]                    req_signed_mode_i,
  input  logic [31:0]                   req_op_a_i,
  input  logic [31:0]                   req_op_b_i,
  input  logic [TagWidth-1:0]           req_tag_i,
  input  logic                          kill_i,
  output logic                          mult_en_o,
  output logic                          div_en_o,
  output logic                          mult_sel_o,
  output logic                          div_sel_o,
  output md_op_e                        operator_o,
  output logic [1:0]                    signed_mode_o,
  output logic [31:0]                   op_a_o,
  output logic [31:0]                   op_b_o,
  output logic [1:0][MD_IMD_W-1:0]      imd_val_q_o,
  input  logic [1:0][MD_IMD_W-1:0]      imd_val_d_i,
  input  logic [1:0]                    imd_val_we_i,
  output logic                          multdiv_ready_id_o,
  input  logic                          multdiv_valid_i,
  input  logic [31:0]                   multdiv_result_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_data_o,
  output logic [TagWidth-1:0]           rsp_tag_o,
  output logic                          busy_o
);

  md_issue_fsm_e       state_q, state_d;
  md_req_t             req_q;
  logic [TagWidth-1:0] tag_q;
  logic [31:0]         rsp_data_q;
  logic                active, accept, capture, is_mul;

  assign active  = (state_q == MDI_BUSY) || (state_q == MDI_DRAIN);
  // Gated by reset so that every output reads 0 while reset is held
  assign req_ready_o = rst_ni & ((state_q == MDI_IDLE) |
                                 ((state_q == MDI_RESP) & rsp_ready_i));
  assign accept  = req_valid_i & req_ready_o;
  assign capture = (state_q == MDI_BUSY) & multdiv_valid_i & ~kill_i;
  assign is_mul  = (req_q.op == MD_OP_MULL) || (req_q.op == MD_OP_MULH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDI_IDLE:  if (accept) state_d = MDI_BUSY;
      MDI_BUSY: begin
        if (multdiv_valid_i) state_d = kill_i ? MDI_IDLE : MDI_RESP;
        else if (kill_i)     state_d = MDI_DRAIN;
      end
      MDI_RESP:  if (rsp_ready_i) state_d = accept ? MDI_BUSY : MDI_IDLE;
      MDI_DRAIN: if (multdiv_valid_i) state_d = MDI_IDLE;
      default:   state_d = MDI_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= MDI_IDLE;
      req_q      <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{op: req_op_i, signed_mode: req_signed_mode_i,
                   op_a: req_op_a_i, op_b: req_op_b_i};
        tag_q <= req_tag_i;
      end
      if (capture) rsp_data_q <= multdiv_result_i;
    end
  end

  cve2_multdiv_imd_regs #(.NumImd(2)) u_imd_regs (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (active),
    .we    (imd_val_we_i),
    .d     (imd_val_d_i),
    .q     (imd_val_q_o)
  );

  // Enables stay up through DRAIN so the multdiv walks back to idle on its own
  assign mult_en_o          = active & is_mul;
  assign mult_sel_o         = active & is_mul;
  assign div_en_o           = active & ~is_mul;
  assign div_sel_o          = active & ~is_mul;
  assign multdiv_ready_id_o = active;
  assign operator_o         = req_q.op;
  assign signed_mode_o      = req_q.signed_mode;
  assign op_a_o             = req_q.op_a;
  assign op_b_o             = req_q.op_b;
  assign rsp_valid_o        = (state_q == MDI_RESP);
  assign rsp_data_o         = rsp_data_q;
  assign rsp_tag_o          = tag_q;
  assign busy_o             = active;

endmodule

// File: tb/tb_cve2_multdiv_issue.sv
// Bench for cve2_multdiv_issue: a behavioural multdiv with fixed latencies drives
// the back end, and a scoreboard checks every popped response against constants.
module tb_cve2_multdiv_issue;
  import cve2_pkg::*;

  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 8;
  localparam int DIV0_LAT = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic                   req_valid = 1'b0, req_ready_o;
  md_op_e                 req_op = MD_OP_MULL;
  logic [1:0]             req_sm = '0;
  logic [31:0]            req_a = '0, req_b = '0;
  logic [4:0]             req_tag = '0;
  logic                   kill = 1'b0;
  logic                   mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  md_op_e                 operator_o;
  logic [1:0]             signed_mode_o;
  logic [31:0]            op_a_o, op_b_o;
  logic [1:0][33:0]       imd_val_q_o;
  logic [1:0][33:0]       imd_d = '0;
  logic [1:0]             imd_we = '0;
  logic                   multdiv_ready_id_o, multdiv_valid_i;
  logic [31:0]            multdiv_result_i;
  logic                   rsp_valid_o, rsp_ready = 1'b1;
  logic [31:0]            rsp_data_o;
  logic [4:0]             rsp_tag_o;
  logic                   busy_o;

  int checks = 0;
  int failures = 0;
  int rsp_cnt = 0;

  cve2_multdiv_issue #(.TagWidth(5)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
    .req_signed_mode_i(req_sm), .req_op_a_i(req_a), .req_op_b_i(req_b),
    .req_tag_i(req_tag), .kill_i(kill),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o),
    .div_sel_o(div_sel_o), .operator_o(operator_o), .signed_mode_o(signed_mode_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .imd_val_q_o(imd_val_q_o),
    .imd_val_d_i(imd_d), .imd_val_we_i(imd_we),
    .multdiv_ready_id_o(multdiv_ready_id_o), .multdiv_valid_i(multdiv_valid_i),
    .multdiv_result_i(multdiv_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
    .rsp_tag_o(rsp_tag_o), .busy_o(busy_o)
  );

  // Behavioural multdiv: counts enabled cycles, result valid on the last one
  function automatic logic [31:0] md_calc(input md_op_e op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    logic               sdiv;
    ea = {sm[0] & a[31], a};
    eb = {sm[1] & b[31], b};
    p  = ea * eb;
    sdiv = (sm == 2'b11);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        if (sdiv) return 32'($signed(a) / $signed(b));
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (sdiv) return 32'($signed(a) % $signed(b));
        return a % b;
      end
    endcase
  endfunction

  int md_cnt;
  int md_lat;
  assign md_lat = mult_en_o ? MUL_LAT : ((op_b_o == 32'd0) ? DIV0_LAT : DIV_LAT);
  assign multdiv_valid_i  = (mult_en_o | div_en_o) && (md_cnt == md_lat - 1);
  assign multdiv_result_i = md_calc(operator_o, signed_mode_o, op_a_o, op_b_o);

  always @(posedge clk) begin
    if (!rst_ni || !(mult_en_o | div_en_o) || (multdiv_valid_i && multdiv_ready_id_o))
      md_cnt <= 0;
    else
      md_cnt <= md_cnt + 1;
  end

  // Scoreboard: expected responses are queued at issue, popped on handshake
  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_ni && rsp_valid_o && rsp_ready) begin
      checks++;
      rsp_cnt++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp got data=%h tag=%h, none expected", rsp_data_o, rsp_tag_o);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_data_o !== mon_e.data || rsp_tag_o !== mon_e.tag) begin
          failures++;
          $display("FAIL rsp_data got data=%h tag=%h required data=%h tag=%h",
                   rsp_data_o, rsp_tag_o, mon_e.data, mon_e.tag);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag,
                      input bit expect_rsp, input logic [31:0] expv);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_sm = sm; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready_o && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b required=1", req_ready_o);
    end
    if (expect_rsp) sb.push_back('{data: expv, tag: tag});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o || rsp_valid_o) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b rsp_valid=%b required 0/0", name, busy_o, rsp_valid_o);
    end
  endtask

  task automatic run_op(input string name, input md_op_e op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] expv, input int exp_busy);
    int n = 0;
    int r0;
    r0 = rsp_cnt;
    send(op, sm, a, b, tag, 1'b1, expv);
    while (busy_o && n < 200) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != exp_busy) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d required=%0d", name, n, exp_busy);
    end
    checks++;
    if (rsp_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_rsp_valid got=%b required=1", name, rsp_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_cnt != r0 + 1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_rsp_count got=%0d valid=%b required=1 valid=0", name, rsp_cnt - r0, rsp_valid_o);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ((|{req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o,
           signed_mode_o, op_a_o, op_b_o, imd_val_q_o, multdiv_ready_id_o,
           rsp_valid_o, rsp_data_o, rsp_tag_o, busy_o}) !== 1'b0 ||
        operator_o !== MD_OP_MULL) begin
      failures++;
      $display("FAIL %s_outputs_zero got rdy=%b busy=%b a=%h b=%h imd=%h rsp=%h tag=%h required all 0",
               name, req_ready_o, busy_o, op_a_o, op_b_o, imd_val_q_o, rsp_data_o, rsp_tag_o);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got ready=%b busy=%b required 1/0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_mull;
    int n = 0;
    int r0;
    r0 = rsp_cnt;
    send(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'h0A, 1'b1, 32'h0000_002A);
    checks++;
    if ({mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o} !== 5'b11001) begin
      failures++;
      $display("FAIL mull_enables got=%b required=11001",
               {mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o});
    end
    checks++;
    if (operator_o !== MD_OP_MULL || op_a_o !== 32'd7 || op_b_o !== 32'd6) begin
      failures++;
      $display("FAIL mull_operands got op=%0d a=%h b=%h required 0/7/6", operator_o, op_a_o, op_b_o);
    end
    imd_d = {34'h1_2345_6789, 34'h3_0000_0001};
    imd_we = 2'b10;
    while (busy_o && n < 200) begin n++; @(posedge clk); #1; imd_we = 2'b00; end
    checks++;
    if (n != MUL_LAT || rsp_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL mull_latency got busy=%0d valid=%b required %0d/1", n, rsp_valid_o, MUL_LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_cnt != r0 + 1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mull_single_rsp got count=%0d required=1", rsp_cnt - r0);
    end
    checks++;
    if (imd_val_q_o[1] !== 34'h1_2345_6789 || imd_val_q_o[0] !== 34'h0) begin
      failures++;
      $display("FAIL imd_busy_write got=%h required=123456789_000000000", imd_val_q_o);
    end
    imd_d = {34'h2_AAAA_AAAA, 34'h1_5555_5555};
    imd_we = 2'b11;
    @(posedge clk); #1;
    imd_we = 2'b00;
    checks++;
    if (imd_val_q_o[1] !== 34'h1_2345_6789 || imd_val_q_o[0] !== 34'h0) begin
      failures++;
      $display("FAIL imd_idle_hold got=%h required=123456789_000000000", imd_val_q_o);
    end
  endtask

  task automatic test_div_rem;
    run_op("div_neg", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'h01, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_neg", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'h02, 32'hFFFF_FFFF, DIV_LAT);
  endtask

  task automatic test_div_zero;
    run_op("div_zero", MD_OP_DIV, 2'b00, 32'd5, 32'd0, 5'h03, 32'hFFFF_FFFF, DIV0_LAT);
    run_op("rem_zero", MD_OP_REM, 2'b00, 32'd5, 32'd0, 5'h04, 32'h0000_0005, DIV0_LAT);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    rsp_ready = 1'b0;
    send(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 5'h15, 1'b1, 32'h4000_0000);
    while (busy_o && n < 200) begin n++; @(posedge clk); #1; end
    // A pending request and a kill must not disturb a completed response
    req_valid = 1'b1; req_op = MD_OP_MULL; req_sm = 2'b00;
    req_a = 32'h10; req_b = 32'h10; req_tag = 5'h03;
    kill = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h4000_0000 ||
          rsp_tag_o !== 5'h15 || req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got valid=%b data=%h tag=%h ready=%b required 1/40000000/15/0",
                 i, rsp_valid_o, rsp_data_o, rsp_tag_o, req_ready_o);
      end
      @(posedge clk); #1;
    end
    kill = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b required=1", req_ready_o);
    end
    sb.push_back('{data: 32'h0000_0100, tag: 5'h03});
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0 || op_a_o !== 32'h10 || mult_en_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got busy=%b valid=%b a=%h mul_en=%b required 1/0/10/1",
               busy_o, rsp_valid_o, op_a_o, mult_en_o);
    end
    wait_idle("b2b");
  endtask

  task automatic test_kill;
    int n = 0;
    send(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'h07, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || div_en_o !== 1'b1 || multdiv_ready_id_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_entry got busy=%b div_en=%b rdy=%b valid=%b required 1/1/1/0",
               busy_o, div_en_o, multdiv_ready_id_o, rsp_valid_o);
    end
    imd_d = {34'h0, 34'h0_CAFE_F00D};
    imd_we = 2'b01;
    while (busy_o && n < 200) begin
      checks++;
      if (div_en_o !== 1'b1 || div_sel_o !== 1'b1 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold got div_en=%b div_sel=%b valid=%b ready=%b required 1/1/0/0",
                 div_en_o, div_sel_o, rsp_valid_o, req_ready_o);
      end
      n++;
      @(posedge clk); #1;
      imd_we = 2'b00;
    end
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_exit got busy=%b valid=%b ready=%b required 0/0/1", busy_o, rsp_valid_o, req_ready_o);
    end
    checks++;
    if (imd_val_q_o[0] !== 34'h0_CAFE_F00D) begin
      failures++;
      $display("FAIL imd_drain_write got=%h required=0cafef00d", imd_val_q_o[0]);
    end
    run_op("mull_after_kill", MD_OP_MULL, 2'b00, 32'd3, 32'd3, 5'h08, 32'd9, MUL_LAT);
    // Kill arriving together with the result drops the result
    n = 0;
    send(MD_OP_DIV, 2'b00, 32'd9, 32'd3, 5'h09, 1'b0, 32'h0);
    while (!multdiv_valid_i && n < 200) begin @(posedge clk); #1; n++; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL kill_with_valid got busy=%b valid=%b ready=%b required 0/0/1", busy_o, rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset_mid_div;
    send(MD_OP_DIV, 2'b00, 32'd50, 32'd5, 5'h0B, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle got ready=%b busy=%b required 1/0", req_ready_o, busy_o);
    end
    run_op("mull_after_reset", MD_OP_MULL, 2'b00, 32'd2, 32'd2, 5'h0C, 32'd4, MUL_LAT);
  endtask

  initial begin
    test_reset();
    test_mull();
    test_div_rem();
    test_div_zero();
    test_back_to_back();
    test_kill();
    test_reset_mid_div();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cve2_multdiv_issue.md
Name: cve2_multdiv_issue

Overview:
Requester-side controller for the slow multiplier/divider. It accepts MUL/DIV requests from the ID stage through a valid/ready handshake and holds the operands stable while the multdiv runs. It drives the multdiv's enable, select and ready signals, owns the two 34-bit intermediate-value registers, and returns the result through a single-entry valid/ready response buffer. It also handles kill and flush by draining the in-flight operation.

Parameters:
TagWidth, 5, width of the opaque request tag (for example rd) returned with the result.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid & ready
req_op_i  in  cve2_pkg::md_op_e  MD_OP_MULL/MULH/DIV/REM
req_signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
req_op_a_i  in  32  operand a
req_op_b_i  in  32  operand b
req_tag_i  in  TagWidth  tag
kill_i  in  1  abandon the current operation
mult_en_o, div_en_o  out  1 each  dynamic enables to multdiv
mult_sel_o, div_sel_o  out  1 each  static selects to multdiv
operator_o  out  md_op_e  registered operator
signed_mode_o  out  2  registered signed mode
op_a_o, op_b_o  out  32 each  registered operands
imd_val_q_o  out  34 x2  intermediate-value register contents
imd_val_d_i  in  34 x2  next intermediate values from multdiv
imd_val_we_i  in  2  per-entry write enables from multdiv
multdiv_ready_id_o  out  1  consumer ready; releases the multdiv hold
multdiv_valid_i  in  1  multdiv result valid
multdiv_result_i  in  32  multdiv result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  32  result
rsp_tag_o  out  TagWidth  tag of the result
busy_o  out  1  high in BUSY or DRAIN

Behaviour:
- States: IDLE, BUSY, RESP, DRAIN. Reset (rst_ni low at a clock edge) puts the FSM in IDLE and clears all registers, including imd_val, operands, tag and rsp_data, to 0.
- Reset output values: every output is 0; operator_o = MD_OP_MULL.
- req_ready_o = (IDLE) | (RESP & rsp_ready_i). It is never high in BUSY or DRAIN.
- Accept (req_valid_i & req_ready_o):
  - Register op, signed mode, operands and tag.
  - Go to BUSY the next cycle.
  - A request accepted in the same cycle as a RESP pop is legal (back-to-back).
- BUSY:
  - mult_en_o/mult_sel_o = (op ∈ {MULL, MULH}); div_en_o/div_sel_o = (op ∈ {DIV, REM}). Exactly one pair is high.
  - multdiv_ready_id_o = 1, because the response buffer is empty in BUSY.
  - On multdiv_valid_i & ~kill_i: capture multdiv_result_i into rsp_data and go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_tag_o are stable until popped.
  - Enables and selects are 0. The multdiv is back in its idle state, so it does not advance.
  - On pop with no new request, go to IDLE. On pop with a new request, go to BUSY.
- kill_i:
  - In BUSY without multdiv_valid_i: go to DRAIN.
  - In BUSY with multdiv_valid_i in the same cycle: the result is discarded and the FSM goes to IDLE. No response is produced.
  - In IDLE or RESP: no effect. A completed response is not killed.
  - In DRAIN: no additional effect.
- DRAIN:
  - Enables, selects and multdiv_ready_id_o stay asserted so the multdiv FSM runs back to its idle state.
  - On multdiv_valid_i: discard the result and go to IDLE. rsp_valid_o = 0 throughout.
- Imd registers: imd_val_q[i] <= imd_val_d_i[i] when imd_val_we_i[i] & (BUSY | DRAIN). Otherwise they hold their value.
- The result is never captured in the same cycle it is produced combinationally. Minimum request-to-response latency is therefore the multdiv latency plus 1 cycle.
- operator_o, signed_mode_o, op_a_o and op_b_o must not change from accept until the FSM leaves BUSY or DRAIN.

Decomposition:
- md_op_e already lives in cve2_pkg.
- Add to cve2_pkg:
  - md_issue_fsm_e {MDI_IDLE, MDI_BUSY, MDI_RESP, MDI_DRAIN}, 2 bits.
  - localparam MD_IMD_W = 34.
- One natural sub-module: cve2_multdiv_imd_regs, the two 34-bit write-enabled intermediate-value registers.
- Top-level integration instantiates cve2_multdiv_issue with the multdiv unit and the ALU.

Test Plan:
1. MULL with a = 7, b = 6, signed mode 00 -> rsp_data = 0x0000002A with the request tag; exactly one response.
2. DIV with a = 0xFFFFFFF9 (-7), b = 2, signed mode 11 -> 0xFFFFFFFD. Then REM with the same operands -> 0xFFFFFFFF.
3. DIV with a = 5, b = 0 -> 0xFFFFFFFF; REM with a = 5, b = 0 -> 0x00000005. Both complete faster than a normal divide.
4. rsp_ready_i held low for 5 cycles after MULH 0x80000000 × 0x80000000 (signed) -> rsp_valid, rsp_data = 0x40000000 and the tag all stable; req_ready_o low. When rsp_ready_i rises together with a new request, the new request is accepted in the same cycle.
5. kill_i pulsed 3 cycles into a DIV -> FSM enters DRAIN, no rsp_valid, enables held until multdiv_valid_i, then IDLE. The next MULL 3 × 3 returns 9.
6. rst_ni low for one cycle mid-DIV -> the next cycle shows all outputs 0 and state IDLE. After the multdiv is reset too, a following MULL 2 × 2 returns 4.
